// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    localparam logic [31:0] NOP_WORD      = 32'b0;
    localparam int          INSTR_BYTES   = 4;
    localparam int          DEFAULT_DEPTH = 2;
    localparam int          CNT_W         = $clog2(DEFAULT_DEPTH + 1);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } fetch_entry_t;

    // Counters must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/if_fetch_stage_fifo.sv
// Circular-buffer fetch queue: push/pop/flush with flush taking priority over push.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC generation, credit-limited imem requests, wrong-path discard and fetch queue.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    loadForwardStall,
    input  logic                    superStall,
    input  logic                    branch_taken,
    input  logic [31:0]             branch_addr,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             Instruction,
    output logic [31:0]             PC,
    output logic                    fetch_valid
);

    localparam int CW = cnt_width(DEPTH);

    logic          hold, pop, push, accept, drop, req_credit;
    logic [CW-1:0] outstanding, outstanding_nxt, discard, fifo_count;
    logic [CW:0]   occupancy;
    logic [31:0]   fetch_pc, resp_pc, branch_target;
    logic [1:0]    unused_addr_bits;
    fetch_entry_t  push_entry, head;

    assign hold          = stall | loadForwardStall | superStall;
    assign fetch_valid   = (fifo_count != '0);
    assign pop           = fetch_valid & ~hold & ~branch_taken;
    assign branch_target = {branch_addr[31:2], 2'b00};
    assign unused_addr_bits = branch_addr[1:0];

    // In-flight plus buffered words never exceed DEPTH, so a push can never overflow.
    assign occupancy  = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
    assign req_credit = occupancy < (CW+1)'(DEPTH);

    assign imem.imem_req_valid = rst & ~branch_taken & req_credit;
    assign imem.imem_req_addr  = fetch_pc;

    assign accept          = imem.imem_req_valid & imem.imem_req_ready;
    assign drop            = imem.imem_resp_valid & ((discard != '0) | branch_taken);
    assign push            = imem.imem_resp_valid & ~drop;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem.imem_resp_valid);
    assign push_entry      = '{word: imem.imem_resp_data, addr: resp_pc};

    // resp_pc is the address of the next response that will be kept; dropped words do not advance it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (branch_taken) begin
                fetch_pc <= branch_target;
                resp_pc  <= branch_target;
                discard  <= outstanding_nxt;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
                if (push)   resp_pc  <= resp_pc + 32'(INSTR_BYTES);
                if (drop)   discard  <= discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (branch_taken),
        .count     (fifo_count),
        .head      (head)
    );

    assign Instruction = fetch_valid ? head.word : NOP_WORD;
    assign PC          = fetch_valid ? head.addr + 32'(INSTR_BYTES) : 32'b0;

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage for the 5-stage pipeline. It generates the fetch PC, issues word requests to a variable-latency instruction memory, and buffers the returned words in a small queue. It drives `Instruction_in`/`PC_in` of the IF/ID pipeline register. Branch redirects flush the queue and discard in-flight responses, so no wrong-path word reaches decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, fetch queue entries and maximum outstanding-plus-buffered words (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- stall  in  1  pipeline hold (same signal the IF/ID register sees)
- loadForwardStall  in  1  pipeline hold
- superStall  in  1  pipeline hold
- branch_taken  in  1  redirect request this cycle
- branch_addr  in  32  redirect target; bits [1:0] ignored, forced to 00
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_resp_valid  in  1  response word valid; in order; one per accepted request
- imem_resp_data  in  32  response word
- Instruction  out  32  queue head word, or 32'b0 (NOP) when empty
- PC  out  32  queue head fetch address + 4, or 32'b0 when empty
- fetch_valid  out  1  queue non-empty

## Operation
- hold = stall | loadForwardStall | superStall.
- pop = fetch_valid & ~hold & ~branch_taken. This is the cycle in which the IF/ID register captures the head.
- State:
  - fetch_pc (32)
  - outstanding: accepted requests, no response yet, 0..DEPTH
  - discard: outstanding responses to drop, 0..outstanding
  - queue: DEPTH entries of {word, addr}
- Request rules:
  - imem_req_valid = ~branch_taken & (outstanding + count − pop < DEPTH).
  - imem_req_valid does not wait for imem_req_ready.
  - Accept = imem_req_valid & imem_req_ready. On accept: fetch_pc += 4 (mod 2^32 wrap), outstanding++.
  - imem_req_addr = fetch_pc, held stable while valid & ~ready.
- Response rules:
  - imem_resp_valid decrements outstanding.
  - If discard > 0 or branch_taken is high the same cycle, the word is dropped and discard is decremented.
  - Otherwise the word is pushed with its address. Addresses are tracked in a parallel address FIFO or by recomputation.
  - Push never overflows; the credit rule guarantees this.
- Branch (branch_taken = 1):
  - fetch_pc ← {branch_addr[31:2], 2'b00}.
  - Queue emptied.
  - discard ← outstanding − (imem_resp_valid ? 1 : 0), computed after the same-cycle accept/response updates.
  - No request is issued that cycle.
- Branch during hold: the branch wins, and the redirect happens regardless of hold.
- Push and pop in the same cycle are legal, including at full or with a single entry.

## Timing
- Reset (rst = 0, asynchronous) values:
  - fetch_pc = RESET_PC
  - outstanding = discard = count = 0
  - Instruction = 0, PC = 0, fetch_valid = 0
  - imem_req_valid = 0
- First request is in the first cycle after rst rises, with addr RESET_PC.
- Latency:
  - A response registered at edge E becomes the head in the cycle after E. There is no response→output bypass.
  - With a 1-cycle memory, the first word appears at Instruction in the 2nd cycle after its request is accepted.
- Throughput: 1 word/cycle sustained with a 1-cycle memory, DEPTH ≥ 2, no hold.
- Outputs Instruction/PC/fetch_valid are purely combinational from queue state.
- imem_req_valid depends combinationally on the hold inputs and branch_taken.
- Reset mid-operation: all state clears immediately. Memory responses to pre-reset requests must not arrive after reset; this is a memory-side obligation.

## Structure
- Shared package if_pkg:
  - NOP_WORD = 32'b0
  - INSTR_BYTES = 4
  - width localparam for counters, $clog2(DEPTH+1)
- Sub-module fetch_fifo (parameter DEPTH, WIDTH = 64):
  - circular buffer
  - push/pop/flush, count, head
  - simultaneous push+pop, flush priority over push
- Top level contains fetch_pc, the credit logic and the discard counter.

## Test plan
- Reset, 1-cycle memory, no hold:
  - Requests 0x0, 0x4, 0x8 are issued on consecutive cycles.
  - The PC outputs are 0x4, 0x8, 0xC, one per cycle from cycle 2.
- Sustained hold (stall = 1 for 5 cycles):
  - Queue fills to DEPTH and imem_req_valid drops.
  - The head is unchanged for all 5 cycles.
  - On release, words resume in order with none lost or duplicated.
- Memory backpressure (imem_req_ready = 0 for 3 cycles):
  - imem_req_addr is held at the same value for those 3 cycles.
  - fetch_pc advances only on the accept.
- Branch to 0x100 with 2 requests outstanding (2-cycle memory):
  - Both responses are dropped.
  - The next valid Instruction comes from 0x100, with PC = 0x104.
- Branch in the same cycle as a response and a hold:
  - The response is dropped and the queue is emptied.
  - fetch_pc = target; no request is issued that cycle.
- Reset asserted mid-stream with a non-empty queue: all outputs go 0 immediately, and fetch restarts at RESET_PC.
